wb_stage_regfile: RTL and testbench

//  Write-back end of the GPR datapath: MEM->WB pipeline register plus a 2R1W
//  GPR file and HI/LO pair. Retires MEM-stage write requests into architectural state.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/regfile_2r1w.sv | 56 +++++
 rtl/wb_stage_regfile.sv | 117 +++++++++++
 tb/tb_wb_stage_regfile.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the GPR write-back datapath.
// wb_req_t carries one MEM-stage retirement request and is also the WB register layout.
package cpu_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam int          XLEN       = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] PC_RESET   = 32'hBFC0_0000;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           pc;
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
    logic                  hilo_we;
    logic [XLEN-1:0]       hi;
    logic [XLEN-1:0]       lo;
  } wb_req_t;

  function automatic wb_req_t wb_empty(input logic [31:0] pc);
    wb_req_t req;
    req.valid   = 1'b0;
    req.pc      = pc;
    req.we      = 1'b0;
    req.waddr   = {REG_ADDR_W{1'b0}};
    req.wdata   = ZERO_WORD;
    req.hilo_we = 1'b0;
    req.hi      = ZERO_WORD;
    req.lo      = ZERO_WORD;
    return req;
  endfunction

  // Squash keeps the payload but drops every side effect of the slot.
  function automatic wb_req_t wb_kill(input wb_req_t req);
    wb_req_t k;
    k         = req;
    k.valid   = 1'b0;
    k.we      = 1'b0;
    k.hilo_we = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write GPR array: r0 reads as zero, same-cycle write is bypassed to reads.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0]     rdata1_o,
  output logic [DATA_W-1:0]     rdata2_o
);

  logic [DATA_W-1:0] r_mem [REG_NUM];
  logic              w_we;

  assign w_we = we_i & (waddr_i != {REG_ADDR_W{1'b0}});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_we) begin
      r_mem[waddr_i] <= wdata_i;
    end else begin
      r_mem <= r_mem;
    end
  end

  // Read mux: r0 first, then the committing write, then the stored value.
  always_comb begin
    rdata1_o = {DATA_W{1'b0}};
    rdata2_o = {DATA_W{1'b0}};
    if (raddr1_i == {REG_ADDR_W{1'b0}}) begin
      rdata1_o = {DATA_W{1'b0}};
    end else if (w_we && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = r_mem[raddr1_i];
    end
    if (raddr2_i == {REG_ADDR_W{1'b0}}) begin
      rdata2_o = {DATA_W{1'b0}};
    end else if (w_we && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = r_mem[raddr2_i];
    end
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// MEM->WB pipeline register, GPR file and HI/LO pair; retires writes into
// architectural state and exports the WB write to forwarding, ID reads and trace debug.
module wb_stage_regfile #(
  parameter int          DATA_W   = 32,
  parameter int          REG_NUM  = 32,
  parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_valid_i,
  input  logic [31:0]       mem_pc_i,
  input  logic              mem_we_i,
  input  logic [4:0]        mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              mem_hilo_we_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  input  logic [4:0]        raddr1_i,
  input  logic [4:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
);
  import cpu_pkg::*;

  // wb_req_t is XLEN wide, so DATA_W is expected to stay at 32.
  wb_req_t           w_mem_req;
  wb_req_t           r_wb;
  logic              w_commit;
  logic              w_hilo_commit;
  logic              w_rf_wen;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // Pack the MEM slot; side effects only count for a real instruction.
  always_comb begin
    w_mem_req         = wb_empty(PC_RESET);
    w_mem_req.valid   = mem_valid_i;
    w_mem_req.pc      = mem_pc_i;
    w_mem_req.we      = mem_we_i & mem_valid_i;
    w_mem_req.waddr   = mem_waddr_i;
    w_mem_req.wdata   = mem_wdata_i;
    w_mem_req.hilo_we = mem_hilo_we_i & mem_valid_i;
    w_mem_req.hi      = mem_hi_i;
    w_mem_req.lo      = mem_lo_i;
  end

  // WB register: flush wins over stall.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wb <= wb_empty(PC_RESET);
    end else if (flush_i) begin
      r_wb <= wb_kill(r_wb);
    end else if (stall_i) begin
      r_wb <= r_wb;
    end else begin
      r_wb <= w_mem_req;
    end
  end

  assign w_commit      = r_wb.valid & ~stall_i;
  assign w_hilo_commit = w_commit & r_wb.hilo_we;
  assign w_rf_wen      = w_commit & r_wb.we & (r_wb.waddr != 5'd0);

  // HI/LO architectural pair.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hi <= {DATA_W{1'b0}};
      r_lo <= {DATA_W{1'b0}};
    end else if (w_hilo_commit) begin
      r_hi <= r_wb.hi;
      r_lo <= r_wb.lo;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (w_commit & r_wb.we),
    .waddr_i  (r_wb.waddr),
    .wdata_i  (r_wb.wdata),
    .raddr1_i (raddr1_i),
    .raddr2_i (raddr2_i),
    .rdata1_o (rdata1_o),
    .rdata2_o (rdata2_o)
  );

  assign hi_o = w_hilo_commit ? r_wb.hi : r_hi;
  assign lo_o = w_hilo_commit ? r_wb.lo : r_lo;

  // Forwarding sees the pending write even while stalled.
  assign wb_we_o    = r_wb.valid & r_wb.we;
  assign wb_waddr_o = r_wb.waddr;
  assign wb_wdata_o = r_wb.wdata;

  assign debug_wb_pc       = r_wb.pc;
  assign debug_wb_rf_wen   = w_rf_wen ? 4'hF : 4'h0;
  assign debug_wb_rf_wnum  = r_wb.waddr;
  assign debug_wb_rf_wdata = r_wb.wdata;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Self-checking bench: directed vector table, reset-mid-stall sequence, then random
// traffic checked against an architectural model (register array + one pending WB slot).
module tb_wb_stage_regfile;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, mem_valid, mem_we, mem_hilo_we;
  logic [31:0] mem_pc, mem_wdata, mem_hi, mem_lo;
  logic [4:0]  mem_waddr, raddr1, raddr2;
  logic [31:0] rdata1, rdata2, wb_wdata, hi_o, lo_o, dbg_pc, dbg_wdata;
  logic        wb_we;
  logic [4:0]  wb_waddr, dbg_wnum;
  logic [3:0]  dbg_wen;

  int n_tests = 0;
  int n_fail  = 0;

  wb_stage_regfile dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_we_i(mem_we),
    .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata), .mem_hilo_we_i(mem_hilo_we),
    .mem_hi_i(mem_hi), .mem_lo_i(mem_lo), .raddr1_i(raddr1), .raddr2_i(raddr2),
    .rdata1_o(rdata1), .rdata2_o(rdata2), .wb_we_o(wb_we), .wb_waddr_o(wb_waddr),
    .wb_wdata_o(wb_wdata), .hi_o(hi_o), .lo_o(lo_o), .debug_wb_pc(dbg_pc),
    .debug_wb_rf_wen(dbg_wen), .debug_wb_rf_wnum(dbg_wnum), .debug_wb_rf_wdata(dbg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, fl, mv, we, hw;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd, hi, lo;
    logic [31:0] e_r1, e_r2, e_hi, e_lo;
    logic        e_wbwe;
    logic [4:0]  e_wbwa;
    logic [3:0]  e_wen;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(input logic st, fl, mv, we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic hw,
                              input logic [31:0] hi, lo, input logic [4:0] ra1, ra2,
                              input logic [31:0] r1, r2, input logic wbwe,
                              input logic [4:0] wbwa, input logic [3:0] wen,
                              input logic [31:0] ehi, elo);
    vec_t v;
    v.st = st; v.fl = fl; v.mv = mv; v.we = we; v.wa = wa; v.wd = wd; v.hw = hw;
    v.hi = hi; v.lo = lo; v.ra1 = ra1; v.ra2 = ra2; v.e_r1 = r1; v.e_r2 = r2;
    v.e_wbwe = wbwe; v.e_wbwa = wbwa; v.e_wen = wen; v.e_hi = ehi; v.e_lo = elo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, fl, mv, we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic hw, input logic [31:0] hi, lo,
                       input logic [4:0] ra1, ra2, input logic [31:0] pc);
    stall = st; flush = fl; mem_valid = mv; mem_we = we; mem_waddr = wa;
    mem_wdata = wd; mem_hilo_we = hw; mem_hi = hi; mem_lo = lo;
    raddr1 = ra1; raddr2 = ra2; mem_pc = pc;
  endtask

  // Architectural model: register array, HI/LO, and the instruction waiting in WB.
  logic [31:0] m_gpr[32];
  logic [31:0] m_hi, m_lo;
  logic        s_valid, s_we, s_hilo;
  logic [4:0]  s_waddr;
  logic [31:0] s_pc, s_wdata, s_hi, s_lo;

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic commit);
    if (a == 5'd0) return 32'd0;
    if (commit && s_we && s_waddr == a) return s_wdata;
    return m_gpr[a];
  endfunction

  task automatic model_step();
    logic commit;
    commit = s_valid && !stall;
    if (commit && s_we && s_waddr != 5'd0) m_gpr[s_waddr] = s_wdata;
    if (commit && s_hilo) begin m_hi = s_hi; m_lo = s_lo; end
    if (flush) begin
      s_valid = 1'b0; s_we = 1'b0; s_hilo = 1'b0;
    end else if (!stall) begin
      s_valid = mem_valid; s_pc = mem_pc; s_we = mem_valid && mem_we;
      s_waddr = mem_waddr; s_wdata = mem_wdata; s_hilo = mem_valid && mem_hilo_we;
      s_hi = mem_hi; s_lo = mem_lo;
    end
  endtask

  task automatic model_check();
    logic commit;
    commit = s_valid && !stall;
    chk("rnd_rdata1", rdata1, m_read(raddr1, commit));
    chk("rnd_rdata2", rdata2, m_read(raddr2, commit));
    chk("rnd_hi", hi_o, (commit && s_hilo) ? s_hi : m_hi);
    chk("rnd_lo", lo_o, (commit && s_hilo) ? s_lo : m_lo);
    chk("rnd_wb_we", {31'd0, wb_we}, {31'd0, s_valid && s_we});
    chk("rnd_rf_wen", {28'd0, dbg_wen},
        (commit && s_we && s_waddr != 5'd0) ? 32'h0000_000F : 32'd0);
    if (s_valid) chk("rnd_dbg_pc", dbg_pc, s_pc);
    if (s_valid && s_we) begin
      chk("rnd_wb_waddr", {27'd0, wb_waddr}, {27'd0, s_waddr});
      chk("rnd_wb_wdata", wb_wdata, s_wdata);
      chk("rnd_dbg_wnum", {27'd0, dbg_wnum}, {27'd0, s_waddr});
      chk("rnd_dbg_wdata", dbg_wdata, s_wdata);
    end
  endtask

  localparam logic [31:0] H = 32'hAAAA_0001;
  localparam logic [31:0] L = 32'h5555_0002;
  localparam logic [31:0] Z = 32'h0;

  initial begin
    //            st fl mv we wa  wd            hw hi lo ra1 ra2 | r1            r2            wbwe wbwa wen   hi lo
    vt[0]  = mk(0, 0, 1, 1, 5,  32'h0000_1234, 0, Z, Z, 5,  0,  Z,            Z,            0, 0,  4'h0, Z, Z);
    vt[1]  = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 5,  5,  32'h1234,     32'h1234,     1, 5,  4'hF, Z, Z);
    vt[2]  = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 5,  0,  32'h1234,     Z,            0, 0,  4'h0, Z, Z);
    vt[3]  = mk(0, 0, 1, 1, 0,  32'hFFFF_FFFF, 0, Z, Z, 0,  0,  Z,            Z,            0, 0,  4'h0, Z, Z);
    vt[4]  = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 0,  5,  Z,            32'h1234,     1, 0,  4'h0, Z, Z);
    vt[5]  = mk(0, 0, 1, 1, 7,  32'h7777_0007, 0, Z, Z, 7,  0,  Z,            Z,            0, 0,  4'h0, Z, Z);
    vt[6]  = mk(1, 0, 0, 0, 0,  Z,             0, Z, Z, 7,  0,  Z,            Z,            1, 7,  4'h0, Z, Z);
    vt[7]  = mk(1, 0, 0, 0, 0,  Z,             0, Z, Z, 7,  0,  Z,            Z,            1, 7,  4'h0, Z, Z);
    vt[8]  = mk(1, 0, 0, 0, 0,  Z,             0, Z, Z, 7,  0,  Z,            Z,            1, 7,  4'h0, Z, Z);
    vt[9]  = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 7,  0,  32'h7777_0007, Z,           1, 7,  4'hF, Z, Z);
    vt[10] = mk(0, 0, 1, 1, 11, 32'h0000_BBBB, 0, Z, Z, 7,  0,  32'h7777_0007, Z,           0, 0,  4'h0, Z, Z);
    vt[11] = mk(1, 1, 1, 1, 9,  32'h0000_9999, 0, Z, Z, 9,  11, Z,            Z,            1, 11, 4'h0, Z, Z);
    vt[12] = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 9,  11, Z,            Z,            0, 0,  4'h0, Z, Z);
    vt[13] = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 9,  11, Z,            Z,            0, 0,  4'h0, Z, Z);
    vt[14] = mk(0, 0, 1, 0, 0,  Z,             1, H, L, 5,  7,  32'h1234,     32'h7777_0007, 0, 0, 4'h0, Z, Z);
    vt[15] = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 5,  7,  32'h1234,     32'h7777_0007, 0, 0, 4'h0, H, L);
    vt[16] = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 5,  7,  32'h1234,     32'h7777_0007, 0, 0, 4'h0, H, L);
    vt[17] = mk(0, 0, 1, 1, 5,  32'h0000_0001, 0, Z, Z, 5,  0,  32'h1234,     Z,            0, 0,  4'h0, H, L);
    vt[18] = mk(0, 0, 1, 1, 5,  32'h0000_0002, 0, Z, Z, 5,  0,  32'h0000_0001, Z,           1, 5,  4'hF, H, L);
    vt[19] = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 5,  0,  32'h0000_0002, Z,           1, 5,  4'hF, H, L);
    vt[20] = mk(0, 0, 0, 0, 0,  Z,             0, Z, Z, 5,  0,  32'h0000_0002, Z,           0, 0,  4'h0, H, L);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 5'd0, Z, 0, Z, Z, 5'd5, 5'd0, Z);
    #12;
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_dbg_pc", dbg_pc, 32'hBFC0_0000);
    chk("rst_rdata1", rdata1, Z);
    chk("rst_hi", hi_o, Z);
    chk("rst_rf_wen", {28'd0, dbg_wen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      drive(vt[i].st, vt[i].fl, vt[i].mv, vt[i].we, vt[i].wa, vt[i].wd, vt[i].hw,
            vt[i].hi, vt[i].lo, vt[i].ra1, vt[i].ra2, 32'h0000_1000 + 32'(i * 4));
      #2;
      chk($sformatf("vec%0d_rdata1", i), rdata1, vt[i].e_r1);
      chk($sformatf("vec%0d_rdata2", i), rdata2, vt[i].e_r2);
      chk($sformatf("vec%0d_wb_we", i), {31'd0, wb_we}, {31'd0, vt[i].e_wbwe});
      if (vt[i].e_wbwe) chk($sformatf("vec%0d_wb_waddr", i), {27'd0, wb_waddr}, {27'd0, vt[i].e_wbwa});
      chk($sformatf("vec%0d_rf_wen", i), {28'd0, dbg_wen}, {28'd0, vt[i].e_wen});
      chk($sformatf("vec%0d_hi", i), hi_o, vt[i].e_hi);
      chk($sformatf("vec%0d_lo", i), lo_o, vt[i].e_lo);
    end

    // r3 write parked in WB by a stall, then reset lands between edges.
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 5'd3, 32'h0000_3333, 0, Z, Z, 5'd3, 5'd5, 32'h0000_2000);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 5'd0, Z, 0, Z, Z, 5'd3, 5'd5, Z);
    #2;
    chk("pre_rst_wb_we", {31'd0, wb_we}, 32'd1);
    chk("pre_rst_rdata2", rdata2, 32'h0000_0002);
    chk("pre_rst_dbg_pc", dbg_pc, 32'h0000_2000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("async_rst_dbg_pc", dbg_pc, 32'hBFC0_0000);
    chk("async_rst_rf_wen", {28'd0, dbg_wen}, 32'd0);
    chk("async_rst_r3", rdata1, Z);
    chk("async_rst_r5", rdata2, Z);
    chk("async_rst_hi", hi_o, Z);
    chk("async_rst_lo", lo_o, Z);
    drive(0, 0, 0, 0, 5'd0, Z, 0, Z, Z, 5'd0, 5'd0, Z);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 32; r++) m_gpr[r] = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    s_valid = 1'b0; s_we = 1'b0; s_hilo = 1'b0; s_waddr = 5'd0;
    s_pc = 32'hBFC0_0000; s_wdata = 32'd0; s_hi = 32'd0; s_lo = 32'd0;

    @(posedge clk); #1;
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0,
            $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            32'h8000_0000 + 32'(c * 4));
      #2;
      model_check();
      model_step();
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
